// File: rtl/alarm_clock_pkg.sv
// Shared constants for the alarm clock datapath.
// Time base defaults and digit width used by counter.
package alarm_clock_pkg;
  localparam int CLKS_PER_SEC_DEF = 256;
  localparam int SECS_PER_MIN_DEF = 60;
  localparam int DIGIT_W          = 4;
endpackage

// File: rtl/timegen_mod_n_counter.sv
// Modulo-N counter with synchronous clear and enable.
// tc is a registered one-cycle strobe on the wrap edge.
module mod_n_counter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_count;
  logic         r_tc;
  logic         w_last;

  assign w_last = (r_count == LAST);

  // Count on enable, wrap at N-1; clear beats counting and kills tc
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= en && w_last;
      if (en) begin
        r_count <= w_last ? '0 : r_count + W'(1);
      end
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
endmodule

// File: rtl/timegen.sv
// Time base: one_second and one_minute strobes from clk.
// fast_watch turns every second into a minute.
module timegen
  import alarm_clock_pkg::*;
#(
  parameter int CLKS_PER_SEC = CLKS_PER_SEC_DEF,
  parameter int SECS_PER_MIN = SECS_PER_MIN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reset_count,
  input  logic       fast_watch,
  output logic       one_second,
  output logic       one_minute,
  output logic [5:0] sec_value
);
  localparam int PW = $clog2(CLKS_PER_SEC);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_SEC - 1);

  if (SECS_PER_MIN > 64 || SECS_PER_MIN < 2 ||
      CLKS_PER_SEC < 2) begin : g_bad_params
    $error("timegen: bad CLKS_PER_SEC/SECS_PER_MIN");
  end

  logic [PW-1:0] w_pre_count;
  logic          w_pre_tc;
  logic          w_pre_last;
  logic [5:0]    w_sec_count;
  logic          w_sec_tc;
  logic          w_sec_clear;
  logic          r_fast_min;

  assign w_pre_last  = (w_pre_count == PRE_LAST);
  assign w_sec_clear = reset_count | fast_watch;

  mod_n_counter #(
    .N(CLKS_PER_SEC),
    .W(PW)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(reset_count),
    .en   (1'b1),
    .count(w_pre_count),
    .tc   (w_pre_tc)
  );

  // Seconds are held at zero while in fast mode
  mod_n_counter #(
    .N(SECS_PER_MIN),
    .W(6)
  ) u_seconds (
    .clk  (clk),
    .reset(reset),
    .clear(w_sec_clear),
    .en   (w_pre_last),
    .count(w_sec_count),
    .tc   (w_sec_tc)
  );

  // Fast-mode minute strobe, aligned with the prescaler wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fast_min <= 1'b0;
    end else begin
      r_fast_min <= !reset_count && fast_watch && w_pre_last;
    end
  end

  assign one_second = w_pre_tc;
  assign one_minute = w_sec_tc | r_fast_min;
  assign sec_value  = w_sec_count;
endmodule

// File: tb/tb_timegen.sv
// Randomized scoreboard bench for timegen.
// Model counts edges since realignment with plain arithmetic.
module tb_timegen;
  localparam int C = 4;
  localparam int S = 3;

  typedef struct {
    logic       sec;
    logic       min;
    logic [5:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reset_count = 1'b0;
  logic       fast_watch = 1'b0;
  logic       one_second;
  logic       one_minute;
  logic [5:0] sec_value;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_edges = 0;
  int   m_sec = 0;

  timegen #(
    .CLKS_PER_SEC(C),
    .SECS_PER_MIN(S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .reset_count(reset_count),
    .fast_watch (fast_watch),
    .one_second (one_second),
    .one_minute (one_minute),
    .sec_value  (sec_value)
  );

  always #5 clk = ~clk;

  // Reference model: edges since alignment, seconds since minute
  always @(posedge clk) begin
    exp_t e;
    e.sec = 1'b0;
    e.min = 1'b0;
    if (reset || reset_count) begin
      m_edges = 0;
      m_sec   = 0;
    end else begin
      m_edges = m_edges + 1;
      e.sec = (m_edges % C == 0);
      if (fast_watch) begin
        m_sec = 0;
        e.min = e.sec;
      end else if (e.sec) begin
        m_sec = m_sec + 1;
        if (m_sec == S) begin
          m_sec = 0;
          e.min = 1'b1;
        end
      end
    end
    e.val = 6'(m_sec);
    q.push_back(e);
  end

  // Monitor: compare every presented output against the queue
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = q.pop_front();
      checks++;
      if (one_second !== e.sec || one_minute !== e.min ||
          sec_value !== e.val) begin
        errors++;
        $display("FAIL outputs t=%0t got s=%b m=%b v=%0d want s=%b m=%b v=%0d",
                 $time, one_second, one_minute, sec_value,
                 e.sec, e.min, e.val);
      end
      checks++;
      if (one_minute === 1'b1 && one_second !== 1'b1) begin
        errors++;
        $display("FAIL min_without_sec t=%0t got s=%b want 1",
                 $time, one_second);
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int found;
    cyc(3);
    reset = 1'b0;
    cyc(40);
    reset = 1'b1;
    cyc(10);
    reset = 1'b0;
    cyc(14);
    fast_watch = 1'b1;
    cyc(16);
    fast_watch = 1'b0;
    cyc(30);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_edges % C == C - 1 && m_sec == S - 1) found = 1;
      else cyc(1);
    end
    if (!found) begin
      errors++;
      $display("FAIL terminal_search got none want sec=%0d pre=%0d",
               S - 1, C - 1);
    end
    reset_count = 1'b1;
    cyc(1);
    reset_count = 1'b0;
    cyc(20);
    reset_count = 1'b1;
    cyc(20);
    reset_count = 1'b0;
    cyc(30);
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      reset_count = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) fast_watch = ~fast_watch;
      cyc(1);
    end
    reset = 1'b0;
    reset_count = 1'b0;
    fast_watch = 1'b0;
    cyc(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
